// File: rtl/brom_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port boot BRAM (one-cycle read latency).
// Build option: define BROM_ARB_WRITE_EN to pass writes to the BRAM; otherwise writes return an error (ROM mode).
module brom_arbiter #(
  parameter int ADDR_WIDTH      = 20,
  parameter int DATA_WIDTH      = 128,
  parameter int BRAM_ADDR_WIDTH = 16,
  localparam int STRB           = DATA_WIDTH / 8
) (
  input  logic                    clka,
  input  logic                    rsta,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB-1:0]       req_wstrb,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]              rsp_err,
  output logic                    bram_ena,
  output logic [STRB-1:0]         bram_wea,
  output logic [ADDR_WIDTH-1:0]   bram_addra,
  output logic [DATA_WIDTH-1:0]   bram_dina,
  input  logic [DATA_WIDTH-1:0]   bram_douta
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  state_t                r_state [2];
  logic                  r_rr;
  logic [1:0]            r_pend_we;
  logic [1:0]            r_pend_err;
  logic [1:0]            r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_data [2];

  logic [1:0]            w_elig;
  logic [1:0]            w_grant;
  logic                  w_gp;
  logic                  w_any;
  logic                  w_we;
  logic                  w_oob;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB-1:0]       w_wstrb;

  // Eligibility, round-robin winner selection and decode of the winning request
  always_comb begin
    w_elig = 2'b00;
    for (int p = 0; p < 2; p++) begin
      w_elig[p] = req_valid[p] & ~rsta &
                  ((r_state[p] == ST_IDLE) | ((r_state[p] == ST_RESP) & rsp_ready[p]));
    end
    w_any = |w_elig;
    if (w_elig == 2'b11) begin
      w_gp = r_rr;
    end else begin
      w_gp = w_elig[1];
    end
    w_grant = w_any ? (2'b01 << w_gp) : 2'b00;
    w_addr  = w_gp ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
    w_wdata = w_gp ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    w_wstrb = w_gp ? req_wstrb[2*STRB-1:STRB]             : req_wstrb[STRB-1:0];
    w_we    = req_we[w_gp];
    w_oob   = |(w_addr >> BRAM_ADDR_WIDTH);
`ifdef BROM_ARB_WRITE_EN
    w_err   = w_oob;
`else
    w_err   = w_oob | w_we;
`endif
  end

  // In ROM mode w_err covers every write, so the write enables fold to zero
  assign req_ready  = w_grant;
  assign bram_ena   = w_any & ~w_err;
  assign bram_wea   = (w_any & ~w_err & w_we) ? w_wstrb : {STRB{1'b0}};
  assign bram_addra = w_addr;
  assign bram_dina  = w_wdata;

  assign rsp_valid = {r_state[1] == ST_RESP, r_state[0] == ST_RESP};
  assign rsp_data  = {r_rsp_data[1], r_rsp_data[0]};
  assign rsp_err   = r_rsp_err;

  // Per-port sequencing, response capture and round-robin pointer update
  always_ff @(posedge clka) begin
    if (rsta) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p]    <= ST_IDLE;
        r_rsp_data[p] <= {DATA_WIDTH{1'b0}};
      end
      r_rr       <= 1'b0;
      r_pend_we  <= 2'b00;
      r_pend_err <= 2'b00;
      r_rsp_err  <= 2'b00;
    end else begin
      if (w_elig == 2'b11) begin
        r_rr <= ~r_rr;
      end
      for (int p = 0; p < 2; p++) begin
        case (r_state[p])
          ST_IDLE: begin
            if (w_grant[p]) begin
              r_state[p]    <= ST_INFLIGHT;
              r_pend_we[p]  <= w_we;
              r_pend_err[p] <= w_err;
            end
          end
          ST_INFLIGHT: begin
            // bram_douta belongs to this port: only one access is issued per cycle
            r_state[p]    <= ST_RESP;
            r_rsp_err[p]  <= r_pend_err[p];
            r_rsp_data[p] <= (r_pend_we[p] | r_pend_err[p]) ? {DATA_WIDTH{1'b0}} : bram_douta;
          end
          ST_RESP: begin
            if (w_grant[p]) begin
              r_state[p]    <= ST_INFLIGHT;
              r_pend_we[p]  <= w_we;
              r_pend_err[p] <= w_err;
            end else if (rsp_ready[p]) begin
              r_state[p] <= ST_IDLE;
            end
          end
          default: begin
            r_state[p] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brom_arbiter.sv
// Self-checking bench for brom_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model and a behavioural one-cycle-latency BRAM.
module tb_brom_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 128;
  localparam int SW  = 16;
  localparam int BAW = 16;
`ifdef BROM_ARB_WRITE_EN
  localparam bit ROM = 1'b0;
`else
  localparam bit ROM = 1'b1;
`endif

  logic            clk = 1'b0;
  logic            rsta;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata, rsp_data;
  logic [2*SW-1:0] req_wstrb;
  logic            bram_ena;
  logic [SW-1:0]   bram_wea;
  logic [AW-1:0]   bram_addra;
  logic [DW-1:0]   bram_dina, bram_douta;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en   = 1'b0;
  bit mem_load = 1'b0;

  always #5 clk = ~clk;

  brom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(BAW)) dut (
    .clka(clk), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta)
  );

  function automatic logic [DW-1:0] init_line(input int i);
    if (i == 1) return 128'h0123456789ABCDEF0123456789ABCDEF;
    return {32'hC0DE0000 + i, ~i, i * 32'h9E3779B9, 32'h5A5A5A5A ^ i};
  endfunction

  // Behavioural BRAM: registered address, read-before-write
  logic [DW-1:0] bram_mem [4096];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) bram_mem[i] <= init_line(i);
    end else if (bram_ena) begin
      bram_douta <= bram_mem[bram_addra[BAW-1:4]];
      for (int b = 0; b < SW; b++)
        if (bram_wea[b]) bram_mem[bram_addra[BAW-1:4]][b*8 +: 8] <= bram_dina[b*8 +: 8];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level reference model: outstanding flag, issue cycle and expected response per port
  logic [DW-1:0] m_mem [4096];
  logic [1:0]    m_out = 2'b00;
  int            m_iss [2];
  logic [DW-1:0] m_exp_data [2];
  logic [1:0]    m_exp_err;
  logic          m_ptr = 1'b0;
  logic [1:0]    mv, elig, exp_rdy;
  int            w;
  logic [AW-1:0] a;
  logic          mwe, merr;
  logic [SW-1:0] ms, exp_wea;
  logic [DW-1:0] md;

  always @(negedge clk) begin
    if (mem_load) for (int i = 0; i < 4096; i++) m_mem[i] = init_line(i);
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        mv[p] = m_out[p] && (cyc - m_iss[p] >= 2);
        n_cmp++;
        if (rsp_valid[p] !== mv[p]) begin
          n_bad++; $display("FAIL mon_rsp_valid[%0d] cyc %0d: got %b expected %b", p, cyc, rsp_valid[p], mv[p]);
        end
        if (mv[p]) begin
          n_cmp++;
          if (rsp_data[p*DW +: DW] !== m_exp_data[p]) begin
            n_bad++; $display("FAIL mon_rsp_data[%0d] cyc %0d: got %h expected %h", p, cyc, rsp_data[p*DW +: DW], m_exp_data[p]);
          end
          n_cmp++;
          if (rsp_err[p] !== m_exp_err[p]) begin
            n_bad++; $display("FAIL mon_rsp_err[%0d] cyc %0d: got %b expected %b", p, cyc, rsp_err[p], m_exp_err[p]);
          end
        end
      end
      if (rsta) begin
        n_cmp++;
        if (req_ready !== 2'b00 || bram_ena !== 1'b0 || bram_wea !== '0) begin
          n_bad++; $display("FAIL mon_reset_outputs cyc %0d: got rdy=%b ena=%b wea=%h expected 0", cyc, req_ready, bram_ena, bram_wea);
        end
        m_out = 2'b00;
        m_ptr = 1'b0;
      end else begin
        elig = req_valid & (~m_out | (mv & rsp_ready));
        if (elig == 2'b00)      w = -1;
        else if (elig == 2'b11) w = int'(m_ptr);
        else                    w = elig[1] ? 1 : 0;
        exp_rdy = (w < 0) ? 2'b00 : (w == 1 ? 2'b10 : 2'b01);
        n_cmp++;
        if (req_ready !== exp_rdy) begin
          n_bad++; $display("FAIL mon_req_ready cyc %0d: got %b expected %b", cyc, req_ready, exp_rdy);
        end
        for (int p = 0; p < 2; p++) if (mv[p] && rsp_ready[p]) m_out[p] = 1'b0;
        if (w < 0) begin
          n_cmp++;
          if (bram_ena !== 1'b0 || bram_wea !== '0) begin
            n_bad++; $display("FAIL mon_idle_bram cyc %0d: got ena=%b wea=%h expected 0", cyc, bram_ena, bram_wea);
          end
        end else begin
          a    = req_addr[w*AW +: AW];
          mwe  = req_we[w];
          ms   = req_wstrb[w*SW +: SW];
          md   = req_wdata[w*DW +: DW];
          merr = (32'(a) >= (32'd1 << BAW)) || (mwe && ROM);
          exp_wea = (!merr && mwe) ? ms : '0;
          n_cmp++;
          if (bram_ena !== !merr || bram_wea !== exp_wea) begin
            n_bad++; $display("FAIL mon_bram_en cyc %0d: got ena=%b wea=%h expected ena=%b wea=%h", cyc, bram_ena, bram_wea, !merr, exp_wea);
          end
          if (!merr) begin
            n_cmp++;
            if (bram_addra !== a || (mwe && bram_dina !== md)) begin
              n_bad++; $display("FAIL mon_bram_addr_data cyc %0d: got %h/%h expected %h/%h", cyc, bram_addra, bram_dina, a, md);
            end
          end
          m_exp_err[w]  = merr;
          m_exp_data[w] = (merr || mwe) ? '0 : m_mem[a[BAW-1:4]];
          if (!merr && mwe)
            for (int b = 0; b < SW; b++) if (ms[b]) m_mem[a[BAW-1:4]][b*8 +: 8] = md[b*8 +: 8];
          m_out[w] = 1'b1;
          m_iss[w] = cyc;
          if (elig == 2'b11) m_ptr = ~m_ptr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 2'b11;
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[p] = 1'b1; req_we[p] = we; req_addr[p*AW +: AW] = ad;
    req_wdata[p*DW +: DW] = d; req_wstrb[p*SW +: SW] = s;
  endtask

  task automatic test_reset();
    mon_en = 1'b1;
    rsta = 1'b1; req_valid = 2'b11;
    tick(); tick(); #1;
    n_cmp++;
    if (req_ready !== 2'b00 || bram_ena !== 1'b0 || bram_wea !== '0) begin
      n_bad++; $display("FAIL reset_req_bram: got rdy=%b ena=%b wea=%h expected 0", req_ready, bram_ena, bram_wea);
    end
    n_cmp++;
    if (rsp_valid !== 2'b00 || rsp_err !== 2'b00 || rsp_data !== '0) begin
      n_bad++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0", rsp_valid, rsp_err, rsp_data);
    end
    tick(); rsta = 1'b0; idle_inputs();
  endtask

  task automatic test_single_read();
    tick(); set_req(0, 1'b0, 20'h00010, '0, '0); #1;
    n_cmp++;
    if (req_ready !== 2'b01 || bram_ena !== 1'b1 || bram_addra !== 20'h00010) begin
      n_bad++; $display("FAIL single_grant: got rdy=%b ena=%b addr=%h expected 01/1/00010", req_ready, bram_ena, bram_addra);
    end
    tick(); req_valid = 2'b00; #1;
    n_cmp++;
    if (rsp_valid[0] !== 1'b0) begin
      n_bad++; $display("FAIL single_n1: got rsp_valid %b expected 0", rsp_valid[0]);
    end
    tick(); #1;
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0 || rsp_data[DW-1:0] !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
      n_bad++; $display("FAIL single_n2: got v=%b e=%b d=%h expected 1/0/line1", rsp_valid[0], rsp_err[0], rsp_data[DW-1:0]);
    end
    tick(); tick();
  endtask

  task automatic test_out_of_range();
    tick(); set_req(0, 1'b0, 20'h10000, '0, '0); #1;
    n_cmp++;
    if (req_ready !== 2'b01 || bram_ena !== 1'b0) begin
      n_bad++; $display("FAIL oob_grant: got rdy=%b ena=%b expected 01/0", req_ready, bram_ena);
    end
    tick(); req_valid = 2'b00; tick(); #1;
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1 || rsp_data[DW-1:0] !== '0) begin
      n_bad++; $display("FAIL oob_rsp: got v=%b e=%b d=%h expected 1/1/0", rsp_valid[0], rsp_err[0], rsp_data[DW-1:0]);
    end
    tick(); tick();
  endtask

  task automatic test_write_then_read();
    logic [DW-1:0] exp_line;
    logic [DW-1:0] wd;
    wd = 128'hAA << 24;
    tick(); set_req(1, 1'b1, 20'h00020, wd, 16'h0008); #1;
    n_cmp++;
    if (req_ready !== 2'b10 || bram_wea !== (ROM ? 16'h0000 : 16'h0008)) begin
      n_bad++; $display("FAIL wr_issue: got rdy=%b wea=%h rom=%b", req_ready, bram_wea, ROM);
    end
    tick(); req_valid = 2'b00; tick(); #1;
    n_cmp++;
    if (rsp_valid[1] !== 1'b1 || rsp_err[1] !== ROM || rsp_data[2*DW-1:DW] !== '0) begin
      n_bad++; $display("FAIL wr_rsp: got v=%b e=%b d=%h expected 1/%b/0", rsp_valid[1], rsp_err[1], rsp_data[2*DW-1:DW], ROM);
    end
    tick(); set_req(0, 1'b0, 20'h00020, '0, '0);
    tick(); req_valid = 2'b00; tick(); #1;
    exp_line = init_line(2);
    if (!ROM) exp_line[31:24] = 8'hAA;
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[DW-1:0] !== exp_line) begin
      n_bad++; $display("FAIL wr_readback: got v=%b d=%h expected 1/%h", rsp_valid[0], rsp_data[DW-1:0], exp_line);
    end
    tick(); tick();
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] nd;
    nd = 128'hFEEDFACE_CAFEBABE_DEADBEEF_12345678;
    tick(); rsp_ready = 2'b01; set_req(1, 1'b0, 20'h00030, '0, '0); #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL bp_first_grant: got %b expected 10", req_ready);
    end
    tick(); set_req(0, 1'b1, 20'h00030, nd, 16'hFFFF); #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL bp_write_grant: got %b expected 01", req_ready);
    end
    tick(); req_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b1 || rsp_data[2*DW-1:DW] !== init_line(3)) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h expected 0/1/%h", i, req_ready[1], rsp_valid[1], rsp_data[2*DW-1:DW], init_line(3));
      end
      tick();
    end
    rsp_ready = 2'b11; #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL bp_release_grant: got %b expected 10", req_ready);
    end
    tick(); req_valid = 2'b00; tick(); #1;
    n_cmp++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[2*DW-1:DW] !== (ROM ? init_line(3) : nd)) begin
      n_bad++; $display("FAIL bp_new_data: got v=%b d=%h", rsp_valid[1], rsp_data[2*DW-1:DW]);
    end
    tick(); tick();
  endtask

  task automatic test_contention();
    logic [1:0] e;
    tick(); rsta = 1'b1; tick(); rsta = 1'b0;
    set_req(0, 1'b0, 20'h00040, '0, '0);
    set_req(1, 1'b0, 20'h00050, '0, '0);
    for (int i = 0; i < 8; i++) begin
      #1;
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (req_ready !== e) begin
        n_bad++; $display("FAIL contention[%0d]: got %b expected %b", i, req_ready, e);
      end
      tick();
    end
    idle_inputs(); tick(); tick(); tick();
  endtask

  task automatic test_reset_midflight();
    tick(); rsta = 1'b1; tick(); rsta = 1'b0;
    set_req(0, 1'b0, 20'h00060, '0, '0);
    set_req(1, 1'b0, 20'h00070, '0, '0); #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid_grant: got %b expected 01", req_ready);
    end
    tick(); rsta = 1'b1;
    tick(); #1;
    n_cmp++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_bad++; $display("FAIL rst_mid_after: got v=%b rdy=%b expected 00/00", rsp_valid, req_ready);
    end
    tick(); rsta = 1'b0; #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid_pointer: got %b expected 01", req_ready);
    end
    tick(); idle_inputs(); tick(); tick(); tick();
  endtask

  task automatic test_random();
    int grants = 0;
    int hs = 0;
    logic [AW-1:0] ad;
    for (int i = 0; i < 600; i++) begin
      tick();
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      for (int p = 0; p < 2; p++) begin
        ad = AW'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) ad = ad | (AW'(1) << $urandom_range(BAW, AW - 1));
        req_we[p] = 1'($urandom_range(0, 1));
        req_addr[p*AW +: AW] = ad;
        req_wdata[p*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        req_wstrb[p*SW +: SW] = SW'($urandom);
      end
      #1;
      grants += $countones(req_valid & req_ready);
      hs     += $countones(rsp_valid & rsp_ready);
    end
    tick(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      #1; hs += $countones(rsp_valid & rsp_ready); tick();
    end
    n_cmp++;
    if (grants !== hs) begin
      n_bad++; $display("FAIL random_completions: got %0d responses expected %0d", hs, grants);
    end
  endtask

  initial begin
    rsta = 1'b1;
    idle_inputs();
    mem_load = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); #1;
    mem_load = 1'b0;
    test_reset();
    test_single_read();
    test_out_of_range();
    test_write_then_read();
    test_back_pressure();
    test_contention();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
